// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single-outstanding
// SETUP/ACCESS sequencer with wait-state timeout and a one-cycle response pulse.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      PSELx,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_WIDTH-1:0]     PRDATA
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [1:0]              req_ready_q, req_ready_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    arb_gnt;

  // Pointer only matters when both requesters compete.
  always_comb begin
    if (req_valid == 2'b11) begin
      arb_gnt = rr_ptr_q;
    end else begin
      arb_gnt = req_valid[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    req_ready_d   = 2'b00;
    rsp_valid_d   = 2'b00;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d     = StSetup;
          grant_d     = arb_gnt;
          rr_ptr_d    = ~arb_gnt;
          cnt_d       = '0;
          psel_d      = 1'b1;
          pwrite_d    = arb_gnt ? req_write[1] : req_write[0];
          paddr_d     = arb_gnt ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                : req_addr[0 +: ADDR_WIDTH];
          pwdata_d    = arb_gnt ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                : req_wdata[0 +: DATA_WIDTH];
          req_ready_d = arb_gnt ? 2'b10 : 2'b01;
        end
      end

      StSetup: begin
        state_d   = StAccess;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      StAccess: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (PREADY) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
          if (cnt_d == TimeoutVal) begin
            state_d       = StIdle;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = grant_q ? 2'b10 : 2'b01;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      rr_ptr_q      <= 1'b0;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      req_ready_q   <= 2'b00;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: table of single transfers against a small
// APB slave memory with programmable wait states, plus contention and reset sequences.
module tb_apb_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .PRDATA     (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: word memory, PREADY after wait_cycles ACCESS cycles, optional error.
  logic [31:0] mem [256];
  int          acc_cnt = 0;
  int          wait_cycles = 0;
  logic        slv_err = 1'b0;

  assign PREADY  = PSELx && PENABLE && (acc_cnt >= wait_cycles);
  assign PSLVERR = slv_err && PREADY;
  assign PRDATA  = mem[PADDR[9:2]];

  always @(posedge PCLK) begin
    if (PRESET) begin
      acc_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PSELx && PENABLE && PREADY && PWRITE && !slv_err) mem[PADDR[9:2]] <= PWDATA;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    int   acc;
    logic [1:0] oh;
    oh = (v.req == 1) ? 2'b10 : 2'b01;
    wait_cycles = v.waits;
    slv_err     = v.slverr;
    @(negedge PCLK);
    req_valid = oh;
    req_write = (v.req == 1) ? 2'b10 & {v.wr, 1'b0} : {1'b0, v.wr};
    req_addr  = (v.req == 1) ? {v.addr, 32'h0} : {32'h0, v.addr};
    req_wdata = (v.req == 1) ? {v.wdata, 32'h0} : {32'h0, v.wdata};
    @(negedge PCLK);
    check("setup_ready", req_ready, oh);
    check("setup_psel", PSELx, 1'b1);
    check("setup_penable", PENABLE, 1'b0);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.wr);
    @(negedge PCLK);
    req_valid = 2'b00;
    check("access_ready_low", req_ready, 2'b00);
    acc = 0;
    while (PENABLE && acc < 40) begin
      acc++;
      check("access_psel", PSELx, 1'b1);
      check("access_paddr", PADDR, v.addr);
      check("access_pwdata", PWDATA, v.wdata);
      check("access_no_rsp", rsp_valid, 2'b00);
      @(negedge PCLK);
    end
    check("access_cycles", acc, v.exp_acc);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", rsp_err, v.exp_err);
    check("rsp_timeout", rsp_timeout, v.exp_to);
    check("rsp_psel_low", PSELx, 1'b0);
    @(negedge PCLK);
    check("rsp_clear_valid", rsp_valid, 2'b00);
    check("rsp_clear_rdata", rsp_rdata, 32'h0);
    check("rsp_clear_err", {rsp_err, rsp_timeout}, 2'b00);
    slv_err = 1'b0;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  initial begin
    int n;
    // req, wr, addr, wdata, waits, slverr, exp_rdata, exp_err, exp_to, exp_acc
    vecs[0] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 0,    1'b0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{0, 1'b0, 32'h10,  32'h0,        0,    1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1};
    vecs[2] = '{1, 1'b1, 32'h20,  32'h12345678, 3,    1'b0, 32'h0,        1'b0, 1'b0, 4};
    vecs[3] = '{1, 1'b0, 32'h20,  32'h0,        1,    1'b0, 32'h12345678, 1'b0, 1'b0, 2};
    vecs[4] = '{1, 1'b1, 32'h1F0, 32'h0000A5A5, 0,    1'b1, 32'h0,        1'b1, 1'b0, 1};
    vecs[5] = '{0, 1'b0, 32'h1F0, 32'h0,        0,    1'b1, 32'h0,        1'b1, 1'b0, 1};
    vecs[6] = '{0, 1'b1, 32'h30,  32'hCAFEF00D, 1000, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    vecs[7] = '{1, 1'b0, 32'h30,  32'h0,        0,    1'b0, 32'h0,        1'b0, 1'b0, 1};

    // Reset state
    @(negedge PCLK);
    check("rst_psel_penable", {PSELx, PENABLE}, 2'b00);
    check("rst_pwrite_paddr", {PWRITE, PADDR}, 33'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_handshake", {req_ready, rsp_valid}, 4'h0);
    check("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention from reset: both held valid, grants must alternate 0,1,0,1
    do_reset();
    wait_cycles = 0;
    req_write = 2'b00;
    req_addr  = {32'h200, 32'h100};
    req_wdata = '0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge PCLK);
        n++;
      end
      check("cont_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      check("cont_paddr", PADDR, (k % 2) ? 32'h200 : 32'h100);
      @(negedge PCLK);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge PCLK);

    // Reset mid-ACCESS drops the transfer; first grant afterwards goes to requester 0
    wait_cycles = 1000;
    req_addr    = {32'h80, 32'h40};
    req_valid   = 2'b01;
    @(negedge PCLK);
    @(negedge PCLK);
    req_valid = 2'b00;
    repeat (3) @(negedge PCLK);
    check("pre_rst_in_access", {PSELx, PENABLE}, 2'b11);
    PRESET = 1'b1;
    #1;
    check("async_rst_apb", {PSELx, PENABLE}, 2'b00);
    check("async_rst_rsp", rsp_valid, 2'b00);
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_cycles = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (rsp_valid != 2'b00 || PSELx) n++;
    end
    check("post_rst_quiet", n, 0);
    req_valid = 2'b11;
    @(negedge PCLK);
    check("post_rst_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    repeat (5) @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master front end.
- Arbitrates round-robin between two local requesters and sequences the granted transfer through the APB SETUP/ACCESS phases.
- Handles slave wait states, PSLVERR and a wait-state timeout, then returns a one-cycle response to the granted requester.
- Sits between on-chip initiators and the APB slave memory block; at most one transfer is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, consecutive ACCESS cycles with PREADY low before the transfer is aborted (must be >= 1)

Ports:
PCLK  in  1  clock; all state updates on the rising edge
PRESET  in  1  reset; asynchronous, active-high
req_valid  in  2  request pending, one bit per requester (bit i = requester i)
req_write  in  2  per-requester direction: 1 = write, 0 = read
req_addr  in  2*ADDR_WIDTH  per-requester address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  per-requester write data, sliced the same way
req_ready  out  2  one-cycle accept pulse to the granted requester
rsp_valid  out  2  one-cycle completion pulse to the granted requester
rsp_rdata  out  DATA_WIDTH  read data, valid while any rsp_valid bit is high
rsp_err  out  1  transfer failed (PSLVERR or timeout), valid with rsp_valid
rsp_timeout  out  1  transfer aborted by timeout, valid with rsp_valid
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error
PRDATA  in  DATA_WIDTH  slave read data

Behaviour:
- All outputs are registered.
- Reset (PRESET high, asynchronous):
  - all outputs go to 0; state goes to IDLE; wait counter 0; round-robin pointer favours requester 0.
  - An in-flight transfer is dropped with no rsp_valid.
  - The first possible grant is at the first rising edge after PRESET is low.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSELx = 0, PENABLE = 0; PADDR, PWRITE and PWDATA hold their last values.
  - If any req_valid bit is set at the edge, grant requester g and latch g's write, addr and wdata into PWRITE, PADDR and PWDATA. Go to SETUP; req_ready[g] = 1 during the SETUP cycle.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the pointer-favoured requester.
  - After each grant the pointer favours the other requester.
- Requester obligations: hold req_valid and its fields stable until the req_ready cycle. Drop req_valid, or present a new request, on the cycle after req_ready.
- SETUP: PSELx = 1, PENABLE = 0. Always lasts exactly 1 cycle, then ACCESS.
- ACCESS: PSELx = 1, PENABLE = 1; PADDR, PWRITE and PWDATA are stable.
  - PREADY = 1 at the edge:
    - go to IDLE; clear PSELx and PENABLE; rsp_valid[g] = 1 for the next cycle.
    - rsp_rdata = PRDATA for a read, 0 for a write.
    - rsp_err = PSLVERR; rsp_timeout = 0.
  - PREADY = 0: increment the wait counter. If the counter reaches TIMEOUT:
    - go to IDLE with rsp_valid[g] = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - The wait counter clears on every entry to SETUP. Its width is clog2(TIMEOUT+1).
- PREADY, PSLVERR and PRDATA are ignored outside ACCESS. PSLVERR is sampled only when PREADY = 1.
- Minimum latency: request sampled at edge 0 -> SETUP in cycle 1 -> ACCESS in cycle 2 -> rsp_valid in cycle 3 (zero-wait slave). Each slave wait cycle adds 1.
- The cycle carrying rsp_valid is in IDLE, so a new transfer can be granted at that cycle's closing edge. There is always at least 1 IDLE cycle between transfers.
- A simultaneous response for g and a new request from g is legal: the new request is arbitrated normally in IDLE.
- rsp_rdata, rsp_err and rsp_timeout return to 0 when no rsp_valid bit is set.
- A PRESET assertion in any state overrides everything.

Test Plan:
- Single write then read, zero-wait slave:
  - Requester 0 writes 0xDEADBEEF to 0x10: req_ready[0] in cycle 1, PSELx=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2, rsp_valid[0] in cycle 3 with rsp_err = 0.
  - Requester 0 then reads 0x10: rsp_rdata = 0xDEADBEEF.
- Contention: both requesters valid at the same edge from reset -> requester 0 granted first, requester 1 granted next. With requester 0 continuously re-requesting, grants alternate 0,1,0,1.
- Wait states: slave holds PREADY low 3 cycles -> PENABLE high 4 cycles; rsp_valid 3 cycles later than the zero-wait case; PADDR and PWDATA stable throughout ACCESS.
- Slave error: read of address 0x1F0 with PSLVERR = 1 on the PREADY cycle -> rsp_err = 1, rsp_timeout = 0.
- Timeout: PREADY tied low with TIMEOUT = 16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, and PSELx dropping to 0.
- Reset mid-ACCESS: assert PRESET during a wait state -> PSELx, PENABLE and all rsp_valid go to 0 immediately. No response is issued, and the first grant after release goes to requester 0.
